// File: rtl/imem_loader_if.sv
// Byte-link and instruction-memory write-port bundle for imem_loader.
// IMEM_LOADER_CHECKSUM_EN adds the checksum_ok status line.
interface imem_loader_if #(
    parameter int n = 32,
    parameter int r = 6
);
    logic         start;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_ready;
    logic         wr_en;
    logic [r-1:0] wr_addr;
    logic [n-1:0] wr_data;
    logic         cpu_hold;
    logic         busy;
    logic         done;
    logic         error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic         checksum_ok;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, checksum_ok
    );
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, checksum_ok
    );
`else
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );
`endif
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: header byte N, then N little-endian n-bit words written from address 0.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int n = 32,
    parameter int r = 6
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int         W     = n / 8;
    localparam int         BW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [8:0] DEPTH = 9'(2 ** r);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR} state_t;

    typedef struct packed {
        logic ready;
        logic wen;
        logic busy;
        logic hold;
        logic done;
        logic err;
    } outs_t;

    // Outputs are registered: every transition loads the decode of the destination state.
    function automatic outs_t decode(state_t s);
        outs_t o;
        o = '0;
        case (s)
            HDR, DATA, CHK: begin o.ready = 1'b1; o.busy = 1'b1; o.hold = 1'b1; end
            WRITE:          begin o.wen   = 1'b1; o.busy = 1'b1; o.hold = 1'b1; end
            DONE:           o.done = 1'b1;
            ERR:            begin o.err   = 1'b1; o.hold = 1'b1; end
            default:        ;
        endcase
        return o;
    endfunction

    state_t         state;
    outs_t          o;
    logic [BW-1:0]  bcnt;
    logic [8:0]     wcnt;
    logic [8:0]     nwords;
    logic [r-1:0]   addr;
    logic [n-1:0]   wdata;
    logic [n-1:0]   asm_q;
    logic [n-1:0]   word_nxt;
    logic           take;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]     sum;
    logic           ck_ok;
`endif

    assign take = bus.byte_valid && o.ready;

    // Assembly buffer is separate from wr_data so the write port holds steady between writes.
    always_comb begin
        word_nxt = asm_q;
        word_nxt[{bcnt, 3'b000} +: 8] = bus.byte_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            o      <= '0;
            bcnt   <= '0;
            wcnt   <= '0;
            nwords <= '0;
            addr   <= '0;
            wdata  <= '0;
            asm_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum    <= '0;
            ck_ok  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state <= HDR;
                        o     <= decode(HDR);
                        bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum   <= '0;
                        ck_ok <= 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (take) begin
                        if (bus.byte_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHK;
                            o     <= decode(CHK);
`else
                            state <= DONE;
                            o     <= decode(DONE);
`endif
                        end else if ({1'b0, bus.byte_data} > DEPTH) begin
                            state <= ERR;
                            o     <= decode(ERR);
                        end else begin
                            nwords <= {1'b0, bus.byte_data};
                            addr   <= '0;
                            wcnt   <= '0;
                            bcnt   <= '0;
                            state  <= DATA;
                            o      <= decode(DATA);
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        asm_q <= word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum   <= sum + bus.byte_data;
`endif
                        if (bcnt == BW'(W - 1)) begin
                            bcnt  <= '0;
                            wdata <= word_nxt;
                            state <= WRITE;
                            o     <= decode(WRITE);
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                WRITE: begin
                    // Address may roll to 0 after writing the top word; no write follows it.
                    addr <= addr + r'(1);
                    wcnt <= wcnt + 9'd1;
                    if (wcnt + 9'd1 == nwords) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= CHK;
                        o     <= decode(CHK);
`else
                        state <= DONE;
                        o     <= decode(DONE);
`endif
                    end else begin
                        state <= DATA;
                        o     <= decode(DATA);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (take) begin
                        if (8'(sum + bus.byte_data) == 8'd0) begin
                            ck_ok <= 1'b1;
                            state <= DONE;
                            o     <= decode(DONE);
                        end else begin
                            state <= ERR;
                            o     <= decode(ERR);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    o     <= decode(IDLE);
                end
            endcase
        end
    end

    assign bus.byte_ready = o.ready;
    assign bus.wr_en      = o.wen;
    assign bus.wr_addr    = addr;
    assign bus.wr_data    = wdata;
    assign bus.cpu_hold   = o.hold;
    assign bus.busy       = o.busy;
    assign bus.done       = o.done;
    assign bus.error      = o.err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.checksum_ok = ck_ok;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes and outcome come from the byte image itself.
module tb_imem_loader;
    localparam int NB    = 32;
    localparam int RB    = 6;
    localparam int WB    = NB / 8;
    localparam int DEPTH = 1 << RB;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    imem_loader_if #(.n(NB), .r(RB)) bus();
    imem_loader #(.n(NB), .r(RB)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    stim[$];
    logic [NB-1:0] exp_words[$];
    bit            exp_ok;
    int            exp_nacc;
    int            wi = 0;
    logic [NB-1:0] last_wd = '0;
    int            acc_cyc[DEPTH];
    logic [NB-1:0] seen_data[$];
    int            seen_addr[$];
    int            seen_cyc[$];
    int            done_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Model: header N, then N words of WB bytes each, least significant byte first.
    function automatic void derive();
        int nw;
        logic [7:0] s;
        exp_words.delete();
        s = '0;
        nw = int'(stim[0]);
        if (nw > DEPTH) begin
            exp_ok = 1'b0;
            exp_nacc = 1;
            return;
        end
        for (int i = 0; i < nw; i++) begin
            logic [NB-1:0] w;
            w = '0;
            for (int k = 0; k < WB; k++) begin
                w = w | (NB'(stim[1 + i*WB + k]) << (8*k));
                s = s + stim[1 + i*WB + k];
            end
            exp_words.push_back(w);
        end
        exp_nacc = 1 + nw*WB;
        if (CK) begin
            exp_ok = (8'(s + stim[exp_nacc]) == 8'h00);
            exp_nacc++;
        end else begin
            exp_ok = 1'b1;
        end
    endfunction

    function automatic void mk_data(input int nw);
        stim.delete();
        stim.push_back(8'(nw));
        if (nw <= DEPTH)
            for (int i = 0; i < nw*WB; i++) stim.push_back(8'($urandom));
    endfunction

    function automatic void add_ck(input bit corrupt);
        logic [7:0] s;
        s = '0;
        if (CK && int'(stim[0]) <= DEPTH) begin
            for (int i = 1; i < stim.size(); i++) s = s + stim[i];
            stim.push_back((8'd0 - s) ^ {7'd0, corrupt});
        end
    endfunction

    // Write-port monitor against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.wr_en) begin
                if (wi >= exp_words.size()) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d want no write", bus.wr_addr);
                end else begin
                    chk("wr_addr", 64'(bus.wr_addr), 64'(wi));
                    chk("wr_data", 64'(bus.wr_data), 64'(exp_words[wi]));
                    chk("wr_ready_low", 64'(bus.byte_ready), 64'(0));
                    chk("wr_latency", 64'(cyc), 64'(acc_cyc[wi] + 1));
                    last_wd = exp_words[wi];
                end
                seen_data.push_back(bus.wr_data);
                seen_addr.push_back(int'(bus.wr_addr));
                seen_cyc.push_back(cyc);
                wi++;
            end else begin
                chk("wr_data_hold", 64'(bus.wr_data), 64'(last_wd));
            end
        end
    end

    task automatic do_reset();
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        last_wd = '0;
        exp_words.delete();
        wi = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_flags", 64'({bus.byte_ready, bus.wr_en, bus.cpu_hold, bus.busy, bus.done, bus.error}), 64'(0));
        chk("reset_addr", 64'(bus.wr_addr), 64'(0));
        chk("reset_data", 64'(bus.wr_data), 64'(0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("reset_ck", 64'(bus.checksum_ok), 64'(0));
`endif
    endtask

    task automatic run_load(input bit gap, input bit mid_start, input int abort_at);
        int idx;
        int budget;
        bit take;
        bit pulsed;
        bit fin;
        idx = 0;
        budget = 0;
        pulsed = 1'b0;
        fin = 1'b0;
        derive();
        wi = 0;
        seen_data.delete();
        seen_addr.delete();
        seen_cyc.delete();
        bus.start = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data = stim[0];
        forever begin
            @(negedge clk);
            take = bus.byte_valid && bus.byte_ready;
            if (take && idx > 0 && idx <= exp_words.size()*WB && (idx - 1) % WB == WB - 1)
                acc_cyc[(idx - 1) / WB] = cyc;
            if (budget > 0 && !take && (bus.done || bus.error)) break;
            @(posedge clk);
            #1 bus.start = 1'b0;
            if (take) idx++;
            if (abort_at > 0 && idx == abort_at) break;
            if (idx >= stim.size()) break;
            budget++;
            if (budget > 4000) begin
                total++;
                bad++;
                $display("FAIL stream_timeout: got %0d bytes want %0d", idx, stim.size());
                break;
            end
            if (mid_start && !pulsed && idx == 3) begin
                bus.start = 1'b1;
                pulsed = 1'b1;
            end
            bus.byte_valid = gap ? 1'($urandom_range(1, 0)) : 1'b1;
            bus.byte_data = bus.byte_valid ? stim[idx] : 8'($urandom);
        end
        bus.byte_valid = 1'b0;
        if (abort_at > 0) return;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            fin = bus.done || bus.error;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL finish_timeout: got done=0 error=0 want one set");
        end
        done_cyc = cyc;
        chk("end_done", 64'(bus.done), 64'(exp_ok));
        chk("end_error", 64'(bus.error), 64'(!exp_ok));
        chk("end_hold", 64'(bus.cpu_hold), 64'(!exp_ok));
        chk("end_busy", 64'(bus.busy), 64'(0));
        chk("end_nwrites", 64'(wi), 64'(exp_words.size()));
        chk("end_naccepted", 64'(idx), 64'(exp_nacc));
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("end_checksum_ok", 64'(bus.checksum_ok), 64'(exp_ok));
`endif
        // Stray bytes after the load must be refused.
        @(posedge clk);
        #1 bus.byte_valid = 1'b1;
        repeat (3) begin
            bus.byte_data = 8'($urandom);
            @(negedge clk);
            chk("idle_ready_low", 64'(bus.byte_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        do_reset();

        // Single word.
        stim = {8'h01, 8'h13, 8'h05, 8'h10, 8'h00};
        add_ck(1'b0);
        run_load(1'b0, 1'b0, 0);
        chk("single_nwrites", 64'(seen_data.size()), 64'(1));
        if (seen_data.size() > 0) begin
            chk("single_data_lit", 64'(seen_data[0]), 64'h0010_0513);
            chk("single_addr_lit", 64'(seen_addr[0]), 64'(0));
`ifndef IMEM_LOADER_CHECKSUM_EN
            chk("single_done_next", 64'(done_cyc), 64'(seen_cyc[0] + 1));
`endif
        end

        // Back-to-back throughput.
        stim.delete();
        stim.push_back(8'd3);
        for (int i = 1; i <= 3; i++)
            repeat (WB) stim.push_back(8'(i * 8'h11));
        add_ck(1'b0);
        run_load(1'b0, 1'b0, 0);
        chk("tp_nwrites", 64'(seen_data.size()), 64'(3));
        if (seen_data.size() == 3) begin
            chk("tp_word2_lit", 64'(seen_data[2]), 64'h3333_3333);
            chk("tp_spacing1", 64'(seen_cyc[1] - seen_cyc[0]), 64'(5));
            chk("tp_spacing2", 64'(seen_cyc[2] - seen_cyc[1]), 64'(5));
        end

        // Header boundaries.
        mk_data(DEPTH);
        add_ck(1'b0);
        run_load(1'b0, 1'b0, 0);
        if (seen_addr.size() > 0)
            chk("full_last_addr", 64'(seen_addr[seen_addr.size() - 1]), 64'(DEPTH - 1));
        stim = {8'(DEPTH + 1)};
        run_load(1'b0, 1'b0, 0);
        chk("over_error_lit", 64'({bus.error, bus.cpu_hold}), 64'(2'b11));
        stim = {8'h00};
        add_ck(1'b0);
        run_load(1'b0, 1'b0, 0);
        chk("zero_nwrites", 64'(seen_data.size()), 64'(0));

        // Gapped stream with a stray start mid-load.
        mk_data(2);
        add_ck(1'b0);
        run_load(1'b1, 1'b1, 0);

        // Reset after 6 data bytes of a 2-word load.
        mk_data(2);
        add_ck(1'b0);
        run_load(1'b0, 1'b0, 1 + 6);
        do_reset();
        chk("abort_nwrites", 64'(seen_data.size()), 64'(1));
        mk_data(2);
        add_ck(1'b0);
        run_load(1'b0, 1'b0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        run_load(1'b0, 1'b0, 0);
        chk("ck_pass_lit", 64'({bus.done, bus.checksum_ok}), 64'(2'b11));
        stim = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        run_load(1'b0, 1'b0, 0);
        chk("ck_fail_lit", 64'({bus.error, bus.checksum_ok}), 64'(2'b10));
        chk("ck_fail_nwrites", 64'(seen_data.size()), 64'(1));
`endif

        // Random loads, chained from DONE/ERR without reset.
        for (int t = 0; t < 10; t++) begin
            int nw;
            nw = ($urandom_range(5, 0) == 0) ? int'($urandom_range(255, DEPTH + 1)) : int'($urandom_range(12, 0));
            mk_data(nw);
            add_ck($urandom_range(3, 0) == 0);
            run_load(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish before 900000");
        $fatal(1, "watchdog");
    end
endmodule
